// File: rtl/cnn_mem_pkg.sv
// ---------------------------------------------------------------------------
// cnn_mem_pkg
// Shared definitions for the CNN memory-side blocks:
//   rd_state_t  - traversal FSM state encoding
//   clog2_min1  - index width helper that never returns a zero-width field
// ---------------------------------------------------------------------------
package cnn_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    // A dimension of 1 still needs a 1-bit index port.
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/lat_pipe.sv
// ---------------------------------------------------------------------------
// lat_pipe
// DEPTH-stage shift register carrying the {valid, last} tag of each issued
// read so both emerge exactly DEPTH cycles later, aligned with memory data.
//   clk, reset           - clock, asynchronous active-high reset
//   in_valid, in_last    - read strobe and final-element tag at issue time
//   out_valid, out_last  - the same tags delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    // NOTE: every stage is reset because these bits are control, not data;
    // a stale 1 left in the pipe after reset would emit a phantom valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read its
            // neighbour's old value, which is what makes this a shift register.
            valid_sr[0] <= in_valid;
            last_sr[0]  <= in_last;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/fmap_mem_reader.sv
// ---------------------------------------------------------------------------
// fmap_mem_reader
// Walks an IMG_W x IMG_H x NUM_CH feature map once per accepted start,
// issuing one memory read per ready cycle, in channel-major (MODE 0) or
// pixel-interleaved (MODE 1) order. Addresses are linear in issue order.
//   clk, reset       - clock, asynchronous active-high reset
//   start            - begin a traversal (honoured only in IDLE / DONE)
//   ready            - downstream accepts a read this cycle
//   addr/ch/row/col  - current read address and its decomposed indices
//   rd_en            - read strobe (combinational: READ state and ready)
//   valid, last      - rd_en / final tag delayed by MEM_LAT cycles
//   busy, done       - traversal in progress / traversal complete
// ---------------------------------------------------------------------------
module fmap_mem_reader
    import cnn_mem_pkg::*;
#(
    parameter  int IMG_W     = 4,
    parameter  int IMG_H     = 4,
    parameter  int NUM_CH    = 12,
    parameter  int START_DLY = 1,
    parameter  int MEM_LAT   = 1,
    parameter  int MODE      = 0,
    localparam int AW        = clog2_min1(IMG_W * IMG_H * NUM_CH),
    localparam int CHW       = clog2_min1(NUM_CH),
    localparam int RW        = clog2_min1(IMG_H),
    localparam int CW        = clog2_min1(IMG_W)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           ready,
    output logic [AW-1:0]  addr,
    output logic [CHW-1:0] ch,
    output logic [RW-1:0]  row,
    output logic [CW-1:0]  col,
    output logic           rd_en,
    output logic           valid,
    output logic           last,
    output logic           busy,
    output logic           done
);

    localparam logic [CHW-1:0] CH_MAX   = CHW'(NUM_CH - 1);
    localparam logic [RW-1:0]  ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [CW-1:0]  COL_MAX  = CW'(IMG_W - 1);
    localparam logic [3:0]     DLY_LAST = 4'(START_DLY - 1);

    rd_state_t  state;
    logic [3:0] dly_cnt;
    logic       ch_max;
    logic       row_max;
    logic       col_max;
    logic       final_elem;

    assign ch_max     = (ch == CH_MAX);
    assign row_max    = (row == ROW_MAX);
    assign col_max    = (col == COL_MAX);
    // All three indices at max is the final element in either ordering.
    assign final_elem = ch_max & row_max & col_max;
    assign rd_en      = (state == ST_READ) && ready;

    lat_pipe #(
        .DEPTH (MEM_LAT)
    ) u_lat_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en),
        .in_last   (rd_en & final_elem),
        .out_valid (valid),
        .out_last  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
            addr    <= '0;
            ch      <= '0;
            row     <= '0;
            col     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dly_cnt <= '0;
                        addr    <= '0;
                        ch      <= '0;
                        row     <= '0;
                        col     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= (START_DLY > 0) ? ST_DELAY : ST_READ;
                    end
                end

                ST_DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        state <= ST_READ;
                    end else begin
                        dly_cnt <= dly_cnt + 4'd1;
                    end
                end

                ST_READ: begin
                    if (ready) begin
                        if (final_elem) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr <= addr + AW'(1);
                            if (MODE == 0) begin
                                // col fastest, then row, then ch
                                col <= col_max ? '0 : col + CW'(1);
                                if (col_max) begin
                                    row <= row_max ? '0 : row + RW'(1);
                                    if (row_max) ch <= ch + CHW'(1);
                                end
                            end else begin
                                // ch fastest, then col, then row
                                ch <= ch_max ? '0 : ch + CHW'(1);
                                if (ch_max) begin
                                    col <= col_max ? '0 : col + CW'(1);
                                    if (col_max) row <= row + RW'(1);
                                end
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    // The final read's tag emerging from the pipe means
                    // nothing else is in flight.
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_fmap_mem_reader
// Four reader instances with different geometries, orders and latencies.
// Expected behaviour comes from a reference model built on plain arithmetic:
// the n-th issued read must carry address n, indices derived by division,
// valid/last appear MEM_LAT cycles after issue, done follows the last valid.
// ---------------------------------------------------------------------------
module tb_fmap_mem_reader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ch;
        logic [31:0] row;
        logic [31:0] col;
        logic [4:0]  flags;  // {rd_en, valid, last, busy, done}
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] start;
    logic [3:0] ready;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Configuration table mirrors the instance parameters below.
    int cfg_w[4]   = '{4, 4, 2, 1};
    int cfg_h[4]   = '{4, 4, 2, 1};
    int cfg_c[4]   = '{12, 12, 1, 1};
    int cfg_dly[4] = '{1, 1, 0, 3};
    int cfg_lat[4] = '{1, 1, 3, 2};
    int cfg_md[4]  = '{0, 1, 0, 1};

    always #5 clk = ~clk;

    // ---- DUT 0: defaults, channel-major ----
    logic [7:0] d0_addr; logic [3:0] d0_ch; logic [1:0] d0_row, d0_col;
    logic d0_rd, d0_v, d0_l, d0_b, d0_d;
    fmap_mem_reader u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .ready(ready[0]),
        .addr(d0_addr), .ch(d0_ch), .row(d0_row), .col(d0_col),
        .rd_en(d0_rd), .valid(d0_v), .last(d0_l), .busy(d0_b), .done(d0_d));

    // ---- DUT 1: defaults, pixel-interleaved ----
    logic [7:0] d1_addr; logic [3:0] d1_ch; logic [1:0] d1_row, d1_col;
    logic d1_rd, d1_v, d1_l, d1_b, d1_d;
    fmap_mem_reader #(.MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .ready(ready[1]),
        .addr(d1_addr), .ch(d1_ch), .row(d1_row), .col(d1_col),
        .rd_en(d1_rd), .valid(d1_v), .last(d1_l), .busy(d1_b), .done(d1_d));

    // ---- DUT 2: 2x2x1, MEM_LAT 3, no start delay ----
    logic [1:0] d2_addr; logic d2_ch, d2_row, d2_col;
    logic d2_rd, d2_v, d2_l, d2_b, d2_d;
    fmap_mem_reader #(.IMG_W(2), .IMG_H(2), .NUM_CH(1), .START_DLY(0), .MEM_LAT(3)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .ready(ready[2]),
        .addr(d2_addr), .ch(d2_ch), .row(d2_row), .col(d2_col),
        .rd_en(d2_rd), .valid(d2_v), .last(d2_l), .busy(d2_b), .done(d2_d));

    // ---- DUT 3: degenerate 1x1x1, START_DLY 3, MEM_LAT 2 ----
    logic d3_addr, d3_ch, d3_row, d3_col;
    logic d3_rd, d3_v, d3_l, d3_b, d3_d;
    fmap_mem_reader #(.IMG_W(1), .IMG_H(1), .NUM_CH(1), .START_DLY(3), .MEM_LAT(2),
                      .MODE(1)) u_dut3 (
        .clk(clk), .reset(reset), .start(start[3]), .ready(ready[3]),
        .addr(d3_addr), .ch(d3_ch), .row(d3_row), .col(d3_col),
        .rd_en(d3_rd), .valid(d3_v), .last(d3_l), .busy(d3_b), .done(d3_d));

    obs_t o0, o1, o2, o3;
    always_comb begin
        o0.addr = 32'(d0_addr); o0.ch = 32'(d0_ch); o0.row = 32'(d0_row); o0.col = 32'(d0_col);
        o0.flags = {d0_rd, d0_v, d0_l, d0_b, d0_d};
        o1.addr = 32'(d1_addr); o1.ch = 32'(d1_ch); o1.row = 32'(d1_row); o1.col = 32'(d1_col);
        o1.flags = {d1_rd, d1_v, d1_l, d1_b, d1_d};
        o2.addr = 32'(d2_addr); o2.ch = 32'(d2_ch); o2.row = 32'(d2_row); o2.col = 32'(d2_col);
        o2.flags = {d2_rd, d2_v, d2_l, d2_b, d2_d};
        o3.addr = 32'(d3_addr); o3.ch = 32'(d3_ch); o3.row = 32'(d3_row); o3.col = 32'(d3_col);
        o3.flags = {d3_rd, d3_v, d3_l, d3_b, d3_d};
    end

    function automatic obs_t cur(input int sel);
        case (sel)
            1:       return o1;
            2:       return o2;
            3:       return o3;
            default: return o0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        obs_t ob;
        ob = cur(sel);
        check({tag, "_addr"}, ob.addr, 0);
        check({tag, "_ch"}, ob.ch, 0);
        check({tag, "_row"}, ob.row, 0);
        check({tag, "_col"}, ob.col, 0);
        check({tag, "_flags"}, 32'(ob.flags), 0);
    endtask

    // Reference decomposition of the k-th read into (ch, row, col).
    function automatic void ref_idx(input int k, input int sel,
                                    output int ech, output int erow, output int ecol);
        int w, h, c;
        w = cfg_w[sel]; h = cfg_h[sel]; c = cfg_c[sel];
        if (cfg_md[sel] == 0) begin
            ecol = k % w; erow = (k / w) % h; ech = k / (w * h);
        end else begin
            ech = k % c; ecol = (k / c) % w; erow = k / (c * w);
        end
    endfunction

    // One traversal on DUT sel. ready is high with probability pct percent.
    // bstart_k >= 0: pulse start while busy whenever k reads have been issued.
    // reset_k  >= 0: assert reset right after the read at address reset_k.
    task automatic run(input int sel, input int pct, input int bstart_k, input int reset_k);
        int   n, k, t, last_v_t, ech, erow, ecol;
        int   q_t[$];
        bit   q_l[$];
        bit   rdy, in_read, exp_rd, exp_v, exp_l, exp_done;
        obs_t ob;
        n = cfg_w[sel] * cfg_h[sel] * cfg_c[sel];
        k = 0; t = 0; last_v_t = -1;

        @(negedge clk);
        start[sel] = 1'b1;
        ready[sel] = 1'b0;

        while (!(last_v_t >= 0 && t >= last_v_t + 2) && t < 5000) begin
            @(negedge clk);
            t++;
            in_read    = (t >= cfg_dly[sel] + 1) && (k < n);
            rdy        = ($urandom_range(99) < pct);
            ready[sel] = rdy;
            start[sel] = in_read && (k == bstart_k);
            #1;
            ob = cur(sel);

            exp_rd = in_read && rdy;
            check("rd_en", 32'(ob.flags[4]), 32'(exp_rd));
            if (in_read) begin
                ref_idx(k, sel, ech, erow, ecol);
                check("addr", ob.addr, k);
                check("ch", ob.ch, ech);
                check("row", ob.row, erow);
                check("col", ob.col, ecol);
            end
            if (exp_rd) begin
                q_t.push_back(t + cfg_lat[sel]);
                q_l.push_back(k == n - 1);
                k++;
            end

            exp_v = (q_t.size() > 0) && (q_t[0] == t);
            exp_l = exp_v && q_l[0];
            if (exp_v) begin
                void'(q_t.pop_front());
                void'(q_l.pop_front());
            end
            if (exp_l) last_v_t = t;
            check("valid", 32'(ob.flags[3]), 32'(exp_v));
            check("last", 32'(ob.flags[2]), 32'(exp_l));

            exp_done = (last_v_t >= 0) && (t > last_v_t);
            check("busy", 32'(ob.flags[1]), 32'(!exp_done));
            check("done", 32'(ob.flags[0]), 32'(exp_done));

            if (reset_k >= 0 && k == reset_k + 1 && exp_rd) begin
                reset = 1'b1;
                #1;
                check_idle(sel, "rst_mid");
                start[sel] = 1'b0;
                ready[sel] = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end

        if (t >= 5000) check("timeout_done", 32'(ob.flags[0]), 1);
        check("reads_issued", k, n);
        start[sel] = 1'b0;
        ready[sel] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = '0;
        ready = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_idle(i, "in_reset");
        reset = 1'b0;
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_idle(i, "post_reset");

        run(0, 100, -1, -1);   // full traversal, ready always high
        run(0, 50, -1, -1);    // start from DONE, random stalls
        run(0, 100, 10, -1);   // start pulsed while busy
        run(0, 70, -1, 50);    // reset mid-traversal
        run(0, 100, -1, -1);   // fresh traversal after abort
        run(1, 100, -1, -1);   // pixel-interleaved order
        run(1, 40, 30, -1);
        run(2, 100, -1, -1);   // deep latency, no start delay
        run(2, 50, -1, -1);
        run(3, 100, -1, -1);   // single-element map
        run(3, 30, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fmap_mem_reader.md
FMAP_MEM_READER -- requirements
Module: fmap_mem_reader

Interface
REQ-001 Parameter IMG_W, default 4: feature-map width in pixels, 1..64.
REQ-002 Parameter IMG_H, default 4: feature-map height in pixels, 1..64.
REQ-003 Parameter NUM_CH, default 12: channel count, 1..64.
REQ-004 Parameter START_DLY, default 1: idle cycles between start acceptance and first read, 0..15.
REQ-005 Parameter MEM_LAT, default 1: memory read latency in cycles, 1..4.
REQ-006 Parameter MODE, default 0: 0 = channel-major (col fastest, then row, then ch); 1 = pixel-interleaved (ch fastest, then col, then row).
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request one full traversal; sampled only in IDLE or DONE.
REQ-010 ready  input  1  downstream can accept a read this cycle; low stalls traversal.
REQ-011 addr  output  AW = clog2(IMG_W*IMG_H*NUM_CH)  memory read address.
REQ-012 ch  output  clog2(NUM_CH), min 1  channel index of current address.
REQ-013 row  output  clog2(IMG_H), min 1  row index of current address.
REQ-014 col  output  clog2(IMG_W), min 1  column index of current address.
REQ-015 rd_en  output  1  read strobe; addr/ch/row/col are valid when high.
REQ-016 valid  output  1  memory data valid; rd_en delayed exactly MEM_LAT cycles.
REQ-017 last  output  1  high with valid for the final element of the traversal.
REQ-018 busy  output  1  high in DELAY, READ, DRAIN.
REQ-019 done  output  1  high in DONE; held until next accepted start or reset.

Function
REQ-020 FSM states: IDLE, DELAY, READ, DRAIN, DONE.
REQ-021 IDLE/DONE + start=1 -> DELAY if START_DLY>0, else READ; counters cleared to 0; done clears the same edge.
REQ-022 DELAY: 4-bit counter increments each cycle; at START_DLY-1 -> READ. ready has no effect in DELAY.
REQ-023 READ: rd_en = ready (combinational); indices advance only when rd_en=1.
REQ-024 addr = ch*IMG_W*IMG_H + row*IMG_W + col (MODE 0); (row*IMG_W + col)*NUM_CH + ch (MODE 1); addr increments by exactly 1 per issued read in both modes.
REQ-025 Index wrap: innermost index at max wraps to 0 and carries to next; outermost at max with the other two at max = final element.
REQ-026 Final element issued -> DRAIN; no further rd_en.
REQ-027 DRAIN: wait until the last in-flight read has produced valid (MEM_LAT cycles after final rd_en), then -> DONE.
REQ-028 Total issued reads per traversal = IMG_W*IMG_H*NUM_CH exactly; no duplicates, no skips, under any ready pattern.
REQ-029 valid pipeline shifts every cycle regardless of ready; ready gates issue only.
REQ-030 last is carried through the same MEM_LAT pipeline as valid, tagging the final read.
REQ-031 start while busy is ignored; traversal unaffected.
REQ-032 ready=0 in READ: counters, addr, ch, row, col hold; rd_en=0.
REQ-033 Degenerate 1x1x1: single read, then DRAIN, DONE.

Reset
REQ-034 Reset forces IDLE; addr, ch, row, col, delay counter, valid pipeline, last pipeline cleared to 0; rd_en, valid, last, busy, done = 0.
REQ-035 Reset mid-traversal aborts immediately; in-flight valid discarded; next start begins at address 0.

Structure
REQ-036 Shared package cnn_mem_pkg holds the FSM state enum and a clog2-with-minimum-1 width function.
REQ-037 One sub-module, lat_pipe: parametrised MEM_LAT-deep shift register carrying {valid, last}, async reset.

Verification
REQ-038 Defaults, ready=1, start pulse -> 1 DELAY cycle, 192 consecutive rd_en, addr 0..191, ch increments every 16, done rises 2 cycles after final rd_en.
REQ-039 MODE=1, 4x4x12, ready=1 -> addr 0..191 sequential; ch cycles 0..11 per pixel; col advances every 12 reads; row 3 col 3 ch 11 at addr 191.
REQ-040 Defaults, ready toggled 1/0 pseudo-randomly -> exactly 192 rd_en, addr strictly sequential, no change while ready=0, last high once with valid.
REQ-041 MEM_LAT=3, 2x2x1 -> valid high exactly 3 cycles after each of 4 rd_en; last with 4th valid; DONE next cycle.
REQ-042 Reset asserted at addr 50 -> all outputs 0 same cycle; new start -> first rd_en at addr 0.
REQ-043 start pulsed at addr 10 while busy -> ignored; traversal completes at addr 191; second start in DONE -> done clears, new traversal runs.
